// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-clock frame, ack check.
// Optional feature: define PS2_TX_RETRY_EN to retry a failed byte once before reporting tx_err.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam int DLY_W = $clog2((INHIBIT_CYCLES > 16) ? INHIBIT_CYCLES : 16) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

    state_t           state;
    state_t           state_d;
    logic             ps2c_p0;
    logic             ps2c_p1;
    logic             ps2c_p2;
    logic             ps2d_p0;
    logic             ps2d_p1;
    logic             fall;
    logic             lines_idle;
    logic             tmo_hit;
    logic             err_now;
    logic             done_now;
    logic             accept;
    logic             retry_ok;
    logic [DLY_W-1:0] dly_cnt;
    logic [3:0]       edge_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       tx_byte;
    logic             tx_par;

    // Bit on the wire after edge_cnt device clock falls: start, D0..D7, parity, stop.
    function automatic logic frame_bit(input logic [3:0] n, input logic [7:0] d, input logic p);
        logic [2:0] idx;
        idx = 3'(n - 4'd1);
        if (n == 4'd0)
            frame_bit = 1'b0;
        else if (n <= 4'd8)
            frame_bit = d[idx];
        else if (n == 4'd9)
            frame_bit = p;
        else
            frame_bit = 1'b1;
    endfunction

    // Synchronizer stage: p0/p1 are the 2-FF chain, ps2c_p2 holds the previous synced clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2c_p0 <= 1'b1;
            ps2c_p1 <= 1'b1;
            ps2c_p2 <= 1'b1;
            ps2d_p0 <= 1'b1;
            ps2d_p1 <= 1'b1;
        end else begin
            ps2c_p0 <= ps2c;
            ps2c_p1 <= ps2c_p0;
            ps2c_p2 <= ps2c_p1;
            ps2d_p0 <= ps2d;
            ps2d_p1 <= ps2d_p0;
        end
    end

    assign fall       = ~ps2c_p1 & ps2c_p2;
    assign lines_idle = ps2c_p1 & ps2d_p1;
    assign tmo_hit    = (tmo_cnt == '0) & ~fall;
    assign accept     = (state == IDLE) & tx_valid;
    assign done_now   = (state == WAIT_IDLE) & lines_idle;

    always_comb begin
        err_now = 1'b0;
        case (state)
            SEND:      err_now = tmo_hit;
            ACK:       err_now = tmo_hit | (fall & ps2d_p1);
            WAIT_IDLE: err_now = tmo_hit & ~lines_idle;
            default:   err_now = 1'b0;
        endcase
    end

`ifdef PS2_TX_RETRY_EN
    logic retry_used;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry_used <= 1'b0;
        else if (accept)
            retry_used <= 1'b0;
        else if (err_now)
            retry_used <= 1'b1;
    end

    assign retry_ok = ~retry_used;
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (tx_valid)
                    state_d = INHIBIT;
            end
            INHIBIT: begin
                if (dly_cnt == '0)
                    state_d = REQ;
            end
            REQ: begin
                if (dly_cnt == '0)
                    state_d = SEND;
            end
            SEND: begin
                if (err_now)
                    state_d = retry_ok ? INHIBIT : IDLE;
                else if (fall && edge_cnt == 4'd9)
                    state_d = ACK;
            end
            ACK: begin
                if (err_now)
                    state_d = retry_ok ? INHIBIT : IDLE;
                else if (fall)
                    state_d = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (done_now)
                    state_d = IDLE;
                else if (err_now)
                    state_d = retry_ok ? INHIBIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (state == IDLE);
        ps2c_oe  = (state == INHIBIT) || (state == REQ);
        tx_done  = done_now;
        tx_err   = err_now & ~retry_ok;
        case (state)
            REQ:     ps2d_oe = 1'b1;
            SEND:    ps2d_oe = ~err_now & ~frame_bit(edge_cnt, tx_byte, tx_par);
            default: ps2d_oe = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_cnt  <= '0;
            edge_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (state_d == INHIBIT && state != INHIBIT)
                dly_cnt <= DLY_W'(INHIBIT_CYCLES - 1);
            else if (state == INHIBIT && state_d == REQ)
                dly_cnt <= DLY_W'(15);
            else if ((state == INHIBIT || state == REQ) && dly_cnt != '0)
                dly_cnt <= dly_cnt - DLY_W'(1);

            if (state_d == INHIBIT && state != INHIBIT)
                edge_cnt <= '0;
            else if (state == SEND && fall)
                edge_cnt <= edge_cnt + 4'd1;

            // The device gets a fresh budget on SEND entry and after every falling edge.
            if ((state_d == SEND && state != SEND) || fall)
                tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
            else if ((state == SEND || state == ACK || state == WAIT_IDLE) && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_byte <= tx_data;
            tx_par  <= ~^tx_data;
        end
    end

endmodule
